// File: rtl/queen_search_controller.sv
// Backtracking control for the N-Queen solver: drives an external LIFO stack and tracks column and diagonal occupancy.
// Latency: one column is tested per cycle. A placement takes 2 cycles (TRY, PLACE) and an undo takes 2 cycles (BACKTRACK, TRY).
// Backpressure: none. The stack is assumed ready every cycle. An overflow or underflow attempt sets the sticky error flag.
//
// Ports:
//   clk, reset (async, active-low)   clock and reset; reset must also clear the attached stack
//   start                            begins a search; accepted only when idle or done
//   stack_top/stack_zero/stack_msb   combinational top entry, empty flag and full flag from the stack
//   push/pop/stack_data              stack commands; an entry is {row, col}
//   busy/done/solution_valid         search status; solution_valid pulses once per complete board
//   solution_count                   number of solutions found in this search, saturating at 127
//   error                            sticky protocol error (push while full, or pop while empty)
module queen_search_controller #(
  parameter int N    = 8,
  parameter int W    = (N > 1) ? $clog2(N) : 1,
  parameter int SIZE = 2 * W
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [SIZE-1:0] stack_top,
  input  logic            stack_zero,
  input  logic            stack_msb,
  output logic            push,
  output logic            pop,
  output logic [SIZE-1:0] stack_data,
  output logic            busy,
  output logic            done,
  output logic            solution_valid,
  output logic [6:0]      solution_count,
  output logic            error
);

  localparam int DW = 2 * N - 1;  // number of diagonals in each direction

  localparam logic [W:0]    C_N     = (W+1)'(N);
  localparam logic [W:0]    C_NM1   = (W+1)'(N - 1);
  localparam logic [W:0]    C_ONE   = (W+1)'(1);
  localparam logic [N-1:0]  C_COL1  = (N)'(1);
  localparam logic [DW-1:0] C_DIAG1 = (DW)'(1);
  localparam logic [6:0]    C_CMAX  = 7'd127;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRY,
    S_PLACE,
    S_SOLUTION,
    S_BACKTRACK,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [W:0]      r_row;
  logic [W:0]      r_col;        // can reach N, which means this row is exhausted
  logic [N-1:0]    r_col_mask;
  logic [DW-1:0]   r_diag_mask;  // indexed by row+col
  logic [DW-1:0]   r_anti_mask;  // indexed by row-col+N-1
  logic [SIZE-1:0] r_stack_data;
  logic [6:0]      r_count;
  logic            r_error;

  // Candidate square (r_row, r_col). These bits are also reused in PLACE
  // because row and col do not change between TRY and PLACE.
  logic [W:0]      w_try_diag_idx;
  logic [W:0]      w_try_anti_idx;
  logic [N-1:0]    w_try_col_bit;
  logic [DW-1:0]   w_try_diag_bit;
  logic [DW-1:0]   w_try_anti_bit;
  logic            w_col_at_end;
  logic            w_safe;

  // Entry being undone in BACKTRACK
  logic [W:0]      w_top_row;
  logic [W:0]      w_top_col;
  logic [W:0]      w_top_diag_idx;
  logic [W:0]      w_top_anti_idx;
  logic [N-1:0]    w_top_col_bit;
  logic [DW-1:0]   w_top_diag_bit;
  logic [DW-1:0]   w_top_anti_bit;

  // The masks are indexed with one-hot shifts. A column equal to N shifts
  // the bit out of the mask, so the result is only used when col < N.
  assign w_try_diag_idx = r_row + r_col;
  assign w_try_anti_idx = r_row + C_NM1 - r_col;
  assign w_try_col_bit  = C_COL1 << r_col;
  assign w_try_diag_bit = C_DIAG1 << w_try_diag_idx;
  assign w_try_anti_bit = C_DIAG1 << w_try_anti_idx;
  assign w_col_at_end   = (r_col == C_N);
  assign w_safe         = !(|(r_col_mask  & w_try_col_bit))  &&
                          !(|(r_diag_mask & w_try_diag_bit)) &&
                          !(|(r_anti_mask & w_try_anti_bit));

  assign w_top_row      = {1'b0, stack_top[SIZE-1:W]};
  assign w_top_col      = {1'b0, stack_top[W-1:0]};
  assign w_top_diag_idx = w_top_row + w_top_col;
  assign w_top_anti_idx = w_top_row + C_NM1 - w_top_col;
  assign w_top_col_bit  = C_COL1 << w_top_col;
  assign w_top_diag_bit = C_DIAG1 << w_top_diag_idx;
  assign w_top_anti_bit = C_DIAG1 << w_top_anti_idx;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) w_next = S_TRY;
      end
      S_TRY: begin
        // A row with no columns left either ends the search (row 0, empty
        // stack) or undoes the queen in the row above.
        if (w_col_at_end)  w_next = stack_zero ? S_DONE : S_BACKTRACK;
        else if (w_safe)   w_next = S_PLACE;
        else               w_next = S_TRY;
      end
      S_PLACE: begin
        w_next = (r_row == C_NM1) ? S_SOLUTION : S_TRY;
      end
      S_SOLUTION:  w_next = S_BACKTRACK;
      S_BACKTRACK: w_next = S_TRY;
      default:     w_next = S_IDLE;
    endcase
  end

  // Search datapath. Updates are keyed by the current state so they line up
  // with the push/pop decodes seen by the stack.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_row        <= '0;
      r_col        <= '0;
      r_col_mask   <= '0;
      r_diag_mask  <= '0;
      r_anti_mask  <= '0;
      r_stack_data <= '0;
      r_count      <= '0;
      r_error      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_row       <= '0;
            r_col       <= '0;
            r_col_mask  <= '0;
            r_diag_mask <= '0;
            r_anti_mask <= '0;
            r_count     <= '0;
            r_error     <= 1'b0;
          end
        end
        S_TRY: begin
          if (!w_col_at_end) begin
            if (w_safe) begin
              // Load the entry now so it is stable for the whole push cycle
              r_stack_data <= {r_row[W-1:0], r_col[W-1:0]};
            end else begin
              r_col <= r_col + C_ONE;
            end
          end
        end
        S_PLACE: begin
          r_col_mask  <= r_col_mask  | w_try_col_bit;
          r_diag_mask <= r_diag_mask | w_try_diag_bit;
          r_anti_mask <= r_anti_mask | w_try_anti_bit;
          if (stack_msb) r_error <= 1'b1;
          if (r_row != C_NM1) begin
            r_row <= r_row + C_ONE;
            r_col <= '0;
          end
        end
        S_SOLUTION: begin
          if (r_count != C_CMAX) r_count <= r_count + 7'd1;
        end
        S_BACKTRACK: begin
          // Resume at the column after the undone queen in its row
          r_col_mask  <= r_col_mask  & ~w_top_col_bit;
          r_diag_mask <= r_diag_mask & ~w_top_diag_bit;
          r_anti_mask <= r_anti_mask & ~w_top_anti_bit;
          r_row       <= w_top_row;
          r_col       <= w_top_col + C_ONE;
          if (stack_zero) r_error <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  // Output decodes of the registered state
  always_comb begin
    push           = 1'b0;
    pop            = 1'b0;
    busy           = 1'b0;
    done           = 1'b0;
    solution_valid = 1'b0;
    case (r_state)
      S_TRY:       busy = 1'b1;
      S_PLACE:     begin busy = 1'b1; push = 1'b1; end
      S_SOLUTION:  begin busy = 1'b1; solution_valid = 1'b1; end
      S_BACKTRACK: begin busy = 1'b1; pop = 1'b1; end
      S_DONE:      done = 1'b1;
      default:     begin end
    endcase
  end

  assign stack_data     = r_stack_data;
  assign solution_count = r_count;
  assign error          = r_error;

endmodule
